// File: rtl/writeback_queue.sv
// writeback_queue: FIFO of completed results ahead of the register bank write port.
// Optional `WB_FORWARD_EN adds qfwdA..qfwdD bypass values for the hazard queries.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_adr,
  input  logic [DW-1:0]              in_value,
  input  logic                       hold,
  output logic                       wenable,
  output logic [AW-1:0]              wadr,
  output logic [DW-1:0]              wvalue,
  input  logic [AW-1:0]              qadrA,
  input  logic [AW-1:0]              qadrB,
  input  logic [AW-1:0]              qadrC,
  input  logic [AW-1:0]              qadrD,
  output logic                       qhitA,
  output logic                       qhitB,
  output logic                       qhitC,
  output logic                       qhitD,
`ifdef WB_FORWARD_EN
  output logic [DW-1:0]              qfwdA,
  output logic [DW-1:0]              qfwdB,
  output logic [DW-1:0]              qfwdC,
  output logic [DW-1:0]              qfwdD,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    mem_adr [DEPTH];
  logic [DW-1:0]    mem_val [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;
  logic             nonempty;
  logic [DEPTH-1:0] live;
  logic [AW-1:0]    qadr [4];
  logic [3:0]       qhit;

  assign nonempty = (cnt != '0);
  assign in_ready = (cnt < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign wenable  = nonempty && !hold;
  assign pop      = wenable;
  assign wadr     = nonempty ? mem_adr[head] : '0;
  assign wvalue   = nonempty ? mem_val[head] : '0;
  assign count    = cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case (1'b1)
        (push && !pop): cnt <= cnt + 1'b1;
        (pop && !push): cnt <= cnt - 1'b1;
        default:        cnt <= cnt;
      endcase
    end
  end

  // Payload needs no reset: only slots covered by cnt are ever observed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_adr[tail] <= in_adr;
      mem_val[tail] <= in_value;
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++)
      live[i] = ({1'b0, PW'(i) - head} < cnt);
  end

  assign qadr[0] = qadrA;
  assign qadr[1] = qadrB;
  assign qadr[2] = qadrC;
  assign qadr[3] = qadrD;

  always_comb begin
    qhit = '0;
    for (int q = 0; q < 4; q++)
      for (int i = 0; i < DEPTH; i++)
        if (live[i] && (mem_adr[i] == qadr[q]))
          qhit[q] = 1'b1;
  end

  assign qhitA = qhit[0];
  assign qhitB = qhit[1];
  assign qhitC = qhit[2];
  assign qhitD = qhit[3];

`ifdef WB_FORWARD_EN
  logic [DW-1:0] qfwd [4];

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    for (int q = 0; q < 4; q++) begin
      qfwd[q] = '0;
      for (int k = 0; k < DEPTH; k++)
        if ((CW'(k) < cnt) &&
            (mem_adr[head + PW'(k)] == qadr[q]))
          qfwd[q] = mem_val[head + PW'(k)];
    end
  end

  assign qfwdA = qfwd[0];
  assign qfwdB = qfwd[1];
  assign qfwdC = qfwd[2];
  assign qfwdD = qfwd[3];
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed and randomized checks of writeback_queue
// against a queue-based reference model.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_adr = '0;
  logic [DW-1:0] in_value = '0;
  logic          hold = 1'b0;
  logic          wenable;
  logic [AW-1:0] wadr;
  logic [DW-1:0] wvalue;
  logic [AW-1:0] qadrA = '0, qadrB = '0, qadrC = '0, qadrD = '0;
  logic          qhitA, qhitB, qhitC, qhitD;
  logic [2:0]    count;
`ifdef WB_FORWARD_EN
  logic [DW-1:0] qfwdA, qfwdB, qfwdC, qfwdD;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] m_adr [$];
  logic [DW-1:0] m_val [$];

  writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_adr(in_adr), .in_value(in_value),
    .hold(hold),
    .wenable(wenable), .wadr(wadr), .wvalue(wvalue),
    .qadrA(qadrA), .qadrB(qadrB), .qadrC(qadrC), .qadrD(qadrD),
    .qhitA(qhitA), .qhitB(qhitB), .qhitC(qhitC), .qhitD(qhitD),
`ifdef WB_FORWARD_EN
    .qfwdA(qfwdA), .qfwdB(qfwdB), .qfwdC(qfwdC), .qfwdD(qfwdD),
`endif
    .count(count)
  );

  always #5 clock = ~clock;

  function automatic logic exp_hit(input logic [AW-1:0] a);
    foreach (m_adr[i]) if (m_adr[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] a);
    for (int i = m_adr.size() - 1; i >= 0; i--)
      if (m_adr[i] == a) return m_val[i];
    return '0;
  endfunction

  // One clock: model applies the same push/pop decision the queue sees.
  task automatic tick();
    bit pu, pp;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    pu = in_valid && (m_adr.size() < DEPTH);
    pp = (m_adr.size() != 0) && !hold;
    a  = in_adr;
    v  = in_value;
    @(posedge clock);
    if (pp) begin
      void'(m_adr.pop_front());
      void'(m_val.pop_front());
    end
    if (pu) begin
      m_adr.push_back(a);
      m_val.push_back(v);
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({wenable, wadr, wvalue, count} !== '0) begin
      n_bad++;
      $display("FAIL reset_out: got we=%0b adr=%0h val=%0h cnt=%0d want all 0",
               wenable, wadr, wvalue, count);
    end
    n_cmp++;
    if ({in_ready, qhitD, qhitC, qhitB, qhitA} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_rdy_hit: got %05b want 10000",
               {in_ready, qhitD, qhitC, qhitB, qhitA});
    end
    reset = 1'b0;
    m_adr.delete();
    m_val.delete();
    tick();
  endtask

  task automatic test_basic();
    hold = 0; in_valid = 1; in_adr = 5'd3; in_value = 32'hDEADBEEF;
    tick();
    in_valid = 0;
    n_cmp++;
    if ({wenable, wadr, wvalue, count} !== {1'b1, 5'd3, 32'hDEADBEEF, 3'd1}) begin
      n_bad++;
      $display("FAIL basic_first: got we=%0b adr=%0d val=%0h cnt=%0d want 1/3/deadbeef/1",
               wenable, wadr, wvalue, count);
    end
    tick();
    n_cmp++;
    if ({wenable, count} !== 4'b0000) begin
      n_bad++;
      $display("FAIL basic_drained: got we=%0b cnt=%0d want 0/0", wenable, count);
    end
  endtask

  task automatic test_hold_full();
    hold = 1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1; in_adr = AW'(i); in_value = 32'h111 * i;
      tick();
    end
    in_valid = 0;
    n_cmp++;
    if ({count, in_ready, wenable} !== {3'd4, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL full_hold: got cnt=%0d rdy=%0b we=%0b want 4/0/0",
               count, in_ready, wenable);
    end
    hold = 0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if ({wenable, wadr, wvalue} !== {1'b1, AW'(i), 32'h111 * i}) begin
        n_bad++;
        $display("FAIL full_drain%0d: got we=%0b adr=%0d val=%0h want 1/%0d/%0h",
                 i, wenable, wadr, wvalue, i, 32'h111 * i);
      end
      tick();
    end
    n_cmp++;
    if (count !== 3'd0) begin
      n_bad++;
      $display("FAIL full_empty: got cnt=%0d want 0", count);
    end
  endtask

  task automatic test_hazard();
    hold = 1;
    in_valid = 1; in_adr = 5'd7; in_value = 32'h7;
    qadrA = 5'd7; qadrB = 5'd9; qadrC = 5'd8; qadrD = 5'd0;
    #1;
    n_cmp++;
    if (qhitA !== 1'b0) begin
      n_bad++;
      $display("FAIL hz_not_yet: got %0b want 0", qhitA);
    end
    tick();
    in_adr = 5'd9; in_value = 32'h9;
    tick();
    in_valid = 0;
    n_cmp++;
    if ({qhitD, qhitC, qhitB, qhitA} !== 4'b0011) begin
      n_bad++;
      $display("FAIL hz_hits: got %04b want 0011", {qhitD, qhitC, qhitB, qhitA});
    end
    hold = 0;
    #1;
    n_cmp++;
    if ({wenable, qhitA} !== 2'b11) begin
      n_bad++;
      $display("FAIL hz_popping: got we=%0b hitA=%0b want 1/1", wenable, qhitA);
    end
    tick();
    tick();
    n_cmp++;
    if ({qhitD, qhitC, qhitB, qhitA} !== 4'b0000) begin
      n_bad++;
      $display("FAIL hz_clear: got %04b want 0000", {qhitD, qhitC, qhitB, qhitA});
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    int bad = 0;
    hold = 0;
    for (int i = 0; i < 11; i++) begin
      a = AW'($urandom); v = $urandom;
      in_valid = 1; in_adr = a; in_value = v;
      tick();
      if ({count, wenable, wadr, wvalue} !== {3'd1, 1'b1, a, v}) begin
        bad++;
        $display("FAIL stream%0d: got cnt=%0d we=%0b adr=%0d val=%0h want 1/1/%0d/%0h",
                 i, count, wenable, wadr, wvalue, a, v);
      end
    end
    in_valid = 0;
    n_cmp++;
    if (bad != 0) n_bad++;
    tick();
    n_cmp++;
    if (count !== 3'd0) begin
      n_bad++;
      $display("FAIL stream_end: got cnt=%0d want 0", count);
    end
  endtask

  task automatic test_async_reset();
    int writes = 0;
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_adr = AW'(20 + i); in_value = $urandom;
      tick();
    end
    in_valid = 0;
    hold = 0;
    #2;
    n_cmp++;
    if ({wenable, count} !== {1'b1, 3'd3}) begin
      n_bad++;
      $display("FAIL ar_pre: got we=%0b cnt=%0d want 1/3", wenable, count);
    end
    reset = 1;
    #1;
    n_cmp++;
    if ({wenable, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL ar_now: got we=%0b cnt=%0d rdy=%0b want 0/0/1",
               wenable, count, in_ready);
    end
    m_adr.delete();
    m_val.delete();
    @(posedge clock);
    #1;
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wenable) writes++;
    end
    n_cmp++;
    if (writes != 0) begin
      n_bad++;
      $display("FAIL ar_nowrite: got %0d writes want 0", writes);
    end
  endtask

`ifdef WB_FORWARD_EN
  task automatic test_forward();
    hold = 1;
    in_valid = 1; in_adr = 5'd5; in_value = 32'h11;
    tick();
    in_value = 32'h22;
    tick();
    in_valid = 0;
    qadrD = 5'd5; qadrA = 5'd6;
    #1;
    n_cmp++;
    if ({qhitD, qfwdD, qhitA, qfwdA} !== {1'b1, 32'h22, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL fwd: got hitD=%0b fwdD=%0h hitA=%0b fwdA=%0h want 1/22/0/0",
               qhitD, qfwdD, qhitA, qfwdA);
    end
    hold = 0;
    repeat (3) tick();
  endtask
`endif

  task automatic test_random();
    logic [3:0] eh;
    int lim = 0;
    for (int c = 0; c < 400; c++) begin
      hold     = ($urandom_range(3) == 0);
      in_valid = ($urandom_range(1) == 1);
      in_adr   = AW'($urandom_range(7));
      in_value = $urandom;
      qadrA = AW'($urandom_range(7)); qadrB = AW'($urandom_range(7));
      qadrC = AW'($urandom_range(7)); qadrD = AW'($urandom_range(7));
      #1;
      eh = {exp_hit(qadrD), exp_hit(qadrC), exp_hit(qadrB), exp_hit(qadrA)};
      n_cmp++;
      if ({count, in_ready} !== {3'(m_adr.size()), 1'(m_adr.size() < DEPTH)}) begin
        n_bad++;
        if (lim++ < 10)
          $display("FAIL rnd_cnt c%0d: got cnt=%0d rdy=%0b want cnt=%0d",
                   c, count, in_ready, m_adr.size());
      end
      n_cmp++;
      if ({wenable, wadr, wvalue} !==
          {1'((m_adr.size() != 0) && !hold),
           (m_adr.size() != 0) ? m_adr[0] : AW'(0),
           (m_adr.size() != 0) ? m_val[0] : DW'(0)}) begin
        n_bad++;
        if (lim++ < 10)
          $display("FAIL rnd_drain c%0d: got we=%0b adr=%0d val=%0h", c, wenable, wadr, wvalue);
      end
      n_cmp++;
      if ({qhitD, qhitC, qhitB, qhitA} !== eh) begin
        n_bad++;
        if (lim++ < 10)
          $display("FAIL rnd_hit c%0d: got %04b want %04b",
                   c, {qhitD, qhitC, qhitB, qhitA}, eh);
      end
`ifdef WB_FORWARD_EN
      n_cmp++;
      if ({qfwdA, qfwdB, qfwdC, qfwdD} !==
          {exp_fwd(qadrA), exp_fwd(qadrB), exp_fwd(qadrC), exp_fwd(qadrD)}) begin
        n_bad++;
        if (lim++ < 10)
          $display("FAIL rnd_fwd c%0d: got %0h %0h %0h %0h", c, qfwdA, qfwdB, qfwdC, qfwdD);
      end
`endif
      tick();
    end
    hold = 0; in_valid = 0;
    repeat (DEPTH + 1) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_full();
    test_hazard();
    test_stream();
    test_async_reset();
`ifdef WB_FORWARD_EN
    test_forward();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Buffers completed results (destination register address + value) ahead of the 32x32 register bank write port.
- Drains one entry per cycle onto wenable/wadr/wvalue.
- Answers up to four read-address hazard queries per cycle, so decode can stall while a read targets a register with a pending write.
- Sits directly upstream of the register bank write port.

Parameters:
DEPTH, 4, number of queue entries; power of 2, minimum 2
AW, 5, register address width
DW, 32, register value width

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears the queue
in_valid  input  1  producer presents a result
in_ready  output  1  queue can accept a result this cycle
in_adr  input  AW  destination register of the incoming result
in_value  input  DW  value of the incoming result
hold  input  1  when 1, suppresses draining (entries retained)
wenable  output  1  write strobe to register bank
wadr  output  AW  write address to register bank
wvalue  output  DW  write data to register bank
qadrA, qadrB, qadrC, qadrD  input  AW each  read addresses to check for hazards
qhitA, qhitB, qhitC, qhitD  output  1 each  a queued entry targets the matching qadr
count  output  clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries {adr, value}, with head/tail pointers of clog2(DEPTH) bits each.
  - Pointers wrap modulo DEPTH.
  - count tracks occupancy from 0 to DEPTH.
- Reset (asynchronous):
  - count=0, head=0, tail=0.
  - Consequently wenable=0, wadr=0, wvalue=0, all qhit=0, in_ready=1.
  - Reset mid-operation discards every entry; none is written to the bank.
- in_ready:
  - Equals (count < DEPTH), derived from registered count only.
  - No same-cycle pass-through: a full queue deasserts in_ready even if a pop occurs that cycle.
- Push: at posedge when in_valid && in_ready; entry written at tail, tail+1.
- Drain outputs:
  - wenable = (count != 0) && !hold.
  - wadr/wvalue show the head entry when count != 0, otherwise 0.
  - These are combinational from registered state, so they are stable for the whole cycle and the bank's negedge write captures them mid-cycle.
- Pop: at posedge when wenable=1; head+1. Each entry is written to the bank exactly once.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Latency: a result pushed at posedge N drives wenable in cycle N+1 if the queue was empty and hold=0.
- Ordering: strict FIFO. Two entries to the same address are written oldest first.
- Hazard query:
  - qhitX = 1 iff any valid entry, including the head, has adr == qadrX.
  - Purely combinational from stored state and qadrX.
  - An entry being pushed this cycle is not visible until the next cycle.
  - An entry being popped this cycle still reports a hit during that cycle.
- Address 0 receives no special treatment; it is queued and written like any other.
- hold=1 with a full queue: in_ready=0; state frozen apart from reset.

Optional Feature:
- Macro: WB_FORWARD_EN
- Defined:
  - Adds outputs qfwdA..qfwdD (DW each).
  - Each carries the value of the youngest valid entry whose adr == qadrX, or 0 when qhitX=0.
  - Allows decode to bypass instead of stall.
- Undefined: qfwd ports and their logic are absent; qhit indicates a stall condition only.

Test Plan:
- Reset, then push {adr=3, value=0xDEADBEEF} -> next cycle wenable=1, wadr=3, wvalue=0xDEADBEEF, count=1; following cycle count=0, wenable=0.
- hold=1, push 4 entries (adr 1,2,3,4) -> count=4, in_ready=0, a fifth push is ignored; release hold -> writes adr 1,2,3,4 in order over 4 consecutive cycles.
- Queue holding adr 7 and adr 9; qadrA=7, qadrB=9, qadrC=8 -> qhitA=1, qhitB=1, qhitC=0; after both drain -> all qhit=0.
- Steady stream, one push per cycle with hold=0 -> count stays at 1 and wenable remains high continuously; wrap-around of pointers past DEPTH preserves order.
- Assert reset asynchronously with 3 entries queued -> count=0 and wenable=0 immediately, no further bank writes.
- (WB_FORWARD_EN) queue holds adr 5=0x11 then adr 5=0x22; qadrD=5 -> qhitD=1, qfwdD=0x22.
